// File: rtl/vx_axi_write_slave_pkg.sv
`default_nettype none
//==============================================================================
// Module      : vx_axi_write_slave_pkg
// Description : Shared encodings for the AXI4 write-channel responder: B
//               response codes, AWBURST encodings and FSM state constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//==============================================================================
package vx_axi_write_slave_pkg;

    // B response codes
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    // AWBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // WRAP and the reserved encoding are not serviced by this responder.
    function automatic logic burst_unsupported(input logic [1:0] burst);
        return (burst == BURST_WRAP) || (burst == BURST_RSVD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_axi_write_slave_burst_addr.sv
`default_nettype none
//==============================================================================
// Module      : vx_axi_write_slave_burst_addr
// Description : Burst line-address register and beat counter. Loaded at AW
//               acceptance, stepped once per accepted W beat.
// Ports       : clk, reset (async, active-low)
//               i_load / i_load_addr / i_load_len : capture burst start
//               i_step / i_incr                   : advance one beat
//               o_addr                            : current line address
//               o_last                            : current beat is the last
// Revision    : 1.0 - initial release
//==============================================================================
module vx_axi_write_slave_burst_addr #(
    parameter int ADDR_WIDTH = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic [7:0]            i_load_len,
    input  logic                  i_step,
    input  logic                  i_incr,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_cnt;
    logic [7:0]            r_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_addr <= i_load_addr;
            r_cnt  <= '0;
            r_len  <= i_load_len;
        end else if (i_step) begin
            r_cnt <= r_cnt + 8'd1;
            // FIXED bursts keep hitting the same line; INCR wraps naturally
            // at the address width.
            if (i_incr) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_cnt == r_len);

endmodule
`default_nettype wire

// File: rtl/vx_axi_write_slave.sv
`default_nettype none
//==============================================================================
// Module      : vx_axi_write_slave
// Description : AXI4 write-channel slave. Accepts one AW burst at a time,
//               forwards each W beat as a memory-bus write request and
//               returns one B response per burst.
// Ports       : clk, reset (async, active-low)
//               s_axi_aw* : address channel in
//               s_axi_w*  : data channel in
//               s_axi_b*  : response channel out
//               mem_req_* : memory-bus write request out
// Revision    : 1.0 - initial release
//==============================================================================
module vx_axi_write_slave
    import vx_axi_write_slave_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_TID_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter int MEM_TAG_WIDTH  = 8,
    parameter int DATA_BYTES     = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [AXI_TID_WIDTH-1:0]  s_axi_awid,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [DATA_BYTES-1:0]     s_axi_wstrb,
    input  logic                      s_axi_wlast,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [AXI_TID_WIDTH-1:0]  s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_rw,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_BYTES-1:0]     mem_req_byteen,
    output logic [AXI_DATA_WIDTH-1:0] mem_req_data,
    output logic [MEM_TAG_WIDTH-1:0]  mem_req_tag
);

    localparam int C_LOG2_BYTES = $clog2(DATA_BYTES);

    logic [1:0]               r_state;
    logic [AXI_TID_WIDTH-1:0] r_id;
    logic [1:0]               r_burst;
    // r_aw_err: burst is unserviceable, beats are drained without writes.
    // r_err   : any error seen so far, reported as SLVERR. A WLAST mismatch
    //           only sets r_err, so the remaining beats are still written.
    logic                     r_aw_err;
    logic                     r_err;

    logic                      w_aw_hs;
    logic                      w_beat_hs;
    logic                      w_last;
    logic                      w_aw_bad;
    logic [MEM_ADDR_WIDTH-1:0] w_line;
    logic [MEM_ADDR_WIDTH-1:0] w_addr;

    assign w_aw_hs   = s_axi_awvalid && (r_state == ST_IDLE);
    assign w_aw_bad  = burst_unsupported(s_axi_awburst)
                    || (s_axi_awsize != 3'(C_LOG2_BYTES));
    assign w_line    = MEM_ADDR_WIDTH'(s_axi_awaddr >> C_LOG2_BYTES);
    assign w_beat_hs = s_axi_wvalid && s_axi_wready;

    vx_axi_write_slave_burst_addr #(
        .ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_burst_addr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_aw_hs),
        .i_load_addr (w_line),
        .i_load_len  (s_axi_awlen),
        .i_step      (w_beat_hs),
        .i_incr      (r_burst == BURST_INCR),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_burst  <= BURST_FIXED;
            r_aw_err <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_id     <= s_axi_awid;
                        r_burst  <= s_axi_awburst;
                        r_aw_err <= w_aw_bad;
                        r_err    <= w_aw_bad;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_hs) begin
                        // The beat counter decides where the burst ends;
                        // WLAST is only cross-checked against it.
                        if (s_axi_wlast != w_last) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (s_axi_bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi_awready = (r_state == ST_IDLE);
    // Zero-latency pass-through of the memory handshake; drained bursts are
    // always ready.
    assign s_axi_wready  = (r_state == ST_DATA) && (r_aw_err || mem_req_ready);
    assign s_axi_bvalid  = (r_state == ST_RESP);
    assign s_axi_bid     = r_id;
    assign s_axi_bresp   = ((r_state == ST_RESP) && r_err) ? BRESP_SLVERR : BRESP_OKAY;

    assign mem_req_valid  = (r_state == ST_DATA) && !r_aw_err && s_axi_wvalid;
    assign mem_req_rw     = 1'b1;
    assign mem_req_addr   = w_addr;
    assign mem_req_byteen = s_axi_wstrb;
    assign mem_req_data   = s_axi_wdata;
    assign mem_req_tag    = MEM_TAG_WIDTH'(r_id);

endmodule
`default_nettype wire

// File: tb/tb_vx_axi_write_slave.sv
`default_nettype none
//==============================================================================
// Module      : tb_vx_axi_write_slave
// Description : Directed self-checking bench for vx_axi_write_slave.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_vx_axi_write_slave;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_axi_awvalid, s_axi_awready;
    logic [31:0]  s_axi_awaddr;
    logic [7:0]   s_axi_awid, s_axi_awlen;
    logic [2:0]   s_axi_awsize;
    logic [1:0]   s_axi_awburst;
    logic         s_axi_wvalid, s_axi_wready, s_axi_wlast;
    logic [511:0] s_axi_wdata;
    logic [63:0]  s_axi_wstrb;
    logic         s_axi_bvalid, s_axi_bready;
    logic [7:0]   s_axi_bid;
    logic [1:0]   s_axi_bresp;
    logic         mem_req_valid, mem_req_ready, mem_req_rw;
    logic [25:0]  mem_req_addr;
    logic [63:0]  mem_req_byteen;
    logic [511:0] mem_req_data;
    logic [7:0]   mem_req_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_axi_write_slave dut (
        .clk            (clk),
        .reset          (reset),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awid     (s_axi_awid),
        .s_axi_awlen    (s_axi_awlen),
        .s_axi_awsize   (s_axi_awsize),
        .s_axi_awburst  (s_axi_awburst),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_wlast    (s_axi_wlast),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_bid      (s_axi_bid),
        .s_axi_bresp    (s_axi_bresp),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_byteen (mem_req_byteen),
        .mem_req_data   (mem_req_data),
        .mem_req_tag    (mem_req_tag)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_data(input int b, input logic [7:0] id);
        return {16{id, 8'(b), 16'hA5C3}};
    endfunction

    function automatic logic [63:0] mk_strb(input int b, input logic [7:0] id);
        return {id, 8'(b), 48'h0000_FFFF_0F0F};
    endfunction

    // One complete burst. wlast_beat: beat index carrying WLAST.
    // ready_mode 0: memory always ready; 1: ready pattern 1,0,0 repeating.
    task automatic run_burst(input logic [31:0] addr, input logic [7:0] id,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int wlast_beat,
                             input logic [25:0] exp_base, input logic exp_incr,
                             input logic exp_drop, input logic [1:0] exp_resp,
                             input int ready_mode, input int bhold);
        int rc;
        logic hs;
        rc = 0;
        // AW phase
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awid = id;
        s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("aw_awready", s_axi_awready, 1'b1);
        chk("idle_wready", s_axi_wready, 1'b0);
        chk("idle_memvalid", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        // W phase
        for (int b = 0; b <= int'(len); b++) begin
            hs = 1'b0;
            for (int t = 0; t < 16 && !hs; t++) begin
                s_axi_wvalid  = 1'b1;
                s_axi_wdata   = mk_data(b, id);
                s_axi_wstrb   = mk_strb(b, id);
                s_axi_wlast   = (b == wlast_beat);
                mem_req_ready = (ready_mode == 0) ? 1'b1 : ((rc % 3) == 0);
                rc++;
                #1;
                chk("data_awready", s_axi_awready, 1'b0);
                chk("data_bvalid", s_axi_bvalid, 1'b0);
                chk("data_wready", s_axi_wready, exp_drop ? 1'b1 : mem_req_ready);
                chk("data_memvalid", mem_req_valid, !exp_drop);
                if (!exp_drop) begin
                    chk("mem_addr", mem_req_addr, exp_base + (exp_incr ? 26'(b) : 26'd0));
                    chk("mem_data", mem_req_data, mk_data(b, id));
                    chk("mem_byteen", mem_req_byteen, mk_strb(b, id));
                    chk("mem_tag", mem_req_tag, id);
                    chk("mem_rw", mem_req_rw, 1'b1);
                end
                hs = s_axi_wready;
                @(posedge clk); #1;
            end
            if (!hs) chk("beat_timeout", 1'b0, 1'b1);
        end
        // RESP phase: keep offering a W beat that must not be taken
        s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("resp_bvalid", s_axi_bvalid, 1'b1);
        chk("resp_bid", s_axi_bid, id);
        chk("resp_bresp", s_axi_bresp, exp_resp);
        chk("resp_wready", s_axi_wready, 1'b0);
        chk("resp_memvalid", mem_req_valid, 1'b0);
        for (int h = 0; h < bhold; h++) begin
            @(posedge clk); #2;
            chk("hold_bvalid", s_axi_bvalid, 1'b1);
            chk("hold_bid", s_axi_bid, id);
            chk("hold_bresp", s_axi_bresp, exp_resp);
            chk("hold_awready", s_axi_awready, 1'b0);
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0; s_axi_wvalid = 1'b0;
        #1;
        chk("post_bvalid", s_axi_bvalid, 1'b0);
        chk("post_awready", s_axi_awready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
        s_axi_awsize = 3'd6; s_axi_awburst = 2'b01;
        s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0; mem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", s_axi_awready, 1'b1);
        chk("rst_wready", s_axi_wready, 1'b0);
        chk("rst_bvalid", s_axi_bvalid, 1'b0);
        chk("rst_bid", s_axi_bid, 8'h00);
        chk("rst_bresp", s_axi_bresp, 2'b00);
        chk("rst_memvalid", mem_req_valid, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // INCR, 4 beats from 0x1000 -> lines 0x40..0x43
        run_burst(32'h1000, 8'h5A, 8'd3, 3'd6, 2'b01, 3, 26'h40, 1'b1, 1'b0, 2'b00, 0, 0);
        // FIXED, 2 beats at line 0x81
        run_burst(32'h2040, 8'h11, 8'd1, 3'd6, 2'b00, 1, 26'h81, 1'b0, 1'b0, 2'b00, 0, 0);
        // WRAP: drained, SLVERR
        run_burst(32'h3000, 8'h22, 8'd3, 3'd6, 2'b10, 3, 26'hC0, 1'b1, 1'b1, 2'b10, 0, 0);
        // INCR 8 beats with memory backpressure
        run_burst(32'h1000, 8'h33, 8'd7, 3'd6, 2'b01, 7, 26'h40, 1'b1, 1'b0, 2'b00, 1, 0);
        // Early WLAST on beat 1: all beats written, SLVERR
        run_burst(32'h4000, 8'h44, 8'd3, 3'd6, 2'b01, 1, 26'h100, 1'b1, 1'b0, 2'b10, 0, 0);
        // Wrong AWSIZE: drained, SLVERR
        run_burst(32'h5000, 8'h55, 8'd1, 3'd5, 2'b01, 1, 26'h140, 1'b1, 1'b1, 2'b10, 0, 0);
        // B held off for 5 cycles
        run_burst(32'h6000, 8'h66, 8'd0, 3'd6, 2'b01, 0, 26'h180, 1'b1, 1'b0, 2'b00, 0, 5);

        // Reset asserted in the middle of a burst
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h7000; s_axi_awid = 8'h77;
        s_axi_awlen = 8'd3; s_axi_awsize = 3'd6; s_axi_awburst = 2'b01;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b0;
        s_axi_wdata = mk_data(0, 8'h77); s_axi_wstrb = mk_strb(0, 8'h77);
        #1;
        chk("mid_memvalid", mem_req_valid, 1'b1);
        chk("mid_memaddr", mem_req_addr, 26'h1C0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_memvalid", mem_req_valid, 1'b0);
        chk("arst_bvalid", s_axi_bvalid, 1'b0);
        chk("arst_wready", s_axi_wready, 1'b0);
        chk("arst_awready", s_axi_awready, 1'b1);
        @(posedge clk); #1;
        chk("arst2_bvalid", s_axi_bvalid, 1'b0);
        chk("arst2_bid", s_axi_bid, 8'h00);
        @(negedge clk); reset = 1'b1; s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        chk("rel_awready", s_axi_awready, 1'b1);
        run_burst(32'h8000, 8'h88, 8'd2, 3'd6, 2'b01, 2, 26'h200, 1'b1, 1'b0, 2'b00, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
